v_alu_array: RTL and testbench

Parametrised multi-channel vector-lane ALU. It holds CH_NUM independent, identical SEW-aware integer ALU channels, each with a PIPE_DEPTH-stage stallable pipeline and a per-channel reduction accumulator. Each channel's result is replicated at element width, and each channel produces a compare-mask bit. It sits in each vector lane between the operand-read stage and the VRF write-back / mask path. It supersedes the fixed 4-channel ALU wrapper, and applies SEW per channel rather than globally.

---
 rtl/v_alu_array.sv | 141 ++++++++++++++
 tb/tb_v_alu_array.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/v_alu_array.sv
// rtl/v_alu_array.sv - multi-channel SEW-aware vector-lane ALU with per-channel reduction accumulators
module v_alu_array #(
  parameter int OP_WIDTH   = 32,
  parameter int CH_NUM     = 4,
  parameter int PIPE_DEPTH = 2,
  parameter int V_LANE_NUM = 1
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [CH_NUM-1:0]            vld_i,
  input  logic [CH_NUM*4-1:0]          op_i,
  input  logic [CH_NUM*2-1:0]          sew_i,
  input  logic [CH_NUM*OP_WIDTH-1:0]   a_i,
  input  logic [CH_NUM*OP_WIDTH-1:0]   b_i,
  input  logic [CH_NUM-1:0]            red_i,
  input  logic [CH_NUM-1:0]            red_first_i,
  input  logic [CH_NUM-1:0]            red_last_i,
  input  logic                         stall_i,
  output logic [CH_NUM*OP_WIDTH-1:0]   res_o,
  output logic [CH_NUM-1:0]            mask_o,
  output logic [CH_NUM-1:0]            vld_o
);

  function automatic logic [31:0] wmask(input logic [1:0] sew);
    case (sew)
      2'b00:   return 32'h0000_00FF;
      2'b01:   return 32'h0000_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] sext(input logic [1:0] sew, input logic [31:0] x);
    case (sew)
      2'b00:   return {{24{x[7]}}, x[7:0]};
      2'b01:   return {{16{x[15]}}, x[15:0]};
      default: return x;
    endcase
  endfunction

  // Operands are zero- and sign-extended from W to 32 bits, computed at 32, then cut back to W.
  function automatic logic [31:0] alu(input logic [3:0] op, input logic [1:0] sew,
                                      input logic [31:0] x, input logic [31:0] y);
    logic [31:0] xu, yu, xs, ys, r;
    logic [4:0]  sh;
    logic        ltu, lts;
    xu  = x & wmask(sew);
    yu  = y & wmask(sew);
    xs  = sext(sew, x);
    ys  = sext(sew, y);
    sh  = y[4:0] & ((sew == 2'b00) ? 5'd7 : (sew == 2'b01) ? 5'd15 : 5'd31);
    ltu = xu < yu;
    lts = $signed(xs) < $signed(ys);
    case (op)
      4'd0:    r = xu + yu;
      4'd1:    r = xu - yu;
      4'd2:    r = xu & yu;
      4'd3:    r = xu | yu;
      4'd4:    r = xu ^ yu;
      4'd5:    r = xu << sh;
      4'd6:    r = xu >> sh;
      4'd7:    r = $unsigned($signed(xs) >>> sh);
      4'd8:    r = ltu ? xu : yu;
      4'd9:    r = lts ? xu : yu;
      4'd10:   r = ltu ? yu : xu;
      4'd11:   r = lts ? yu : xu;
      4'd12:   r = {31'b0, xu == yu};
      4'd13:   r = {31'b0, xu != yu};
      4'd14:   r = {31'b0, ltu};
      default: r = {31'b0, lts};
    endcase
    return r & wmask(sew);
  endfunction

  function automatic logic [OP_WIDTH-1:0] rep(input logic [1:0] sew, input logic [31:0] r);
    logic [OP_WIDTH-1:0] o;
    o = '0;
    for (int i = 0; i < OP_WIDTH / 8; i++) begin
      case (sew)
        2'b00:   o[8*i +: 8] = r[7:0];
        2'b01:   o[8*i +: 8] = r[8*(i%2) +: 8];
        default: o[8*i +: 8] = r[8*(i%4) +: 8];
      endcase
    end
    return o;
  endfunction

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [31:0]         a, b, acc_q, acc_n, res;
    logic [3:0]          op;
    logic [1:0]          sew;
    logic                take, pipe_vld, legal_red;
    logic [PIPE_DEPTH-1:0] vq, mq;
    logic [OP_WIDTH-1:0] dq [PIPE_DEPTH];

    assign a         = a_i[c*OP_WIDTH +: 32];
    assign b         = b_i[c*OP_WIDTH +: 32];
    assign op        = op_i[c*4 +: 4];
    assign sew       = sew_i[c*2 +: 2];
    assign take      = vld_i[c] & ~stall_i;
    assign legal_red = (op <= 4'd4) || ((op >= 4'd8) && (op <= 4'd11));

    // A reduction element only enters the pipeline when it is the last one.
    always_comb begin
      acc_n    = '0;
      res      = '0;
      pipe_vld = 1'b0;
      if (legal_red) acc_n = alu(op, sew, red_first_i[c] ? b : acc_q, a);
      else           acc_n = a & wmask(sew);
      res      = red_i[c] ? acc_n : alu(op, sew, a, b);
      pipe_vld = red_i[c] ? red_last_i[c] : 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rstn) begin
        vq    <= '0;
        mq    <= '0;
        acc_q <= '0;
        for (int s = 0; s < PIPE_DEPTH; s++) dq[s] <= '0;
      end else if (!stall_i) begin
        vq[0] <= take & pipe_vld;
        if (take & pipe_vld) begin
          dq[0] <= rep(sew, res);
          mq[0] <= res[0];
        end
        if (take & red_i[c]) acc_q <= acc_n;
        for (int s = 1; s < PIPE_DEPTH; s++) begin
          vq[s] <= vq[s-1];
          if (vq[s-1]) begin
            dq[s] <= dq[s-1];
            mq[s] <= mq[s-1];
          end
        end
      end
    end

    assign res_o[c*OP_WIDTH +: OP_WIDTH] = dq[PIPE_DEPTH-1];
    assign mask_o[c]                     = mq[PIPE_DEPTH-1];
    assign vld_o[c]                      = vq[PIPE_DEPTH-1];
  end

endmodule

// File: tb/tb_v_alu_array.sv
// tb/tb_v_alu_array.sv - directed self-checking bench for v_alu_array
module tb_v_alu_array;
  localparam int OPW = 32;
  localparam int CHN = 4;
  localparam int PD  = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic [CHN-1:0]   vld_i, red_i, red_first_i, red_last_i;
  logic [CHN*4-1:0] op_i;
  logic [CHN*2-1:0] sew_i;
  logic [CHN*OPW-1:0] a_i, b_i, res_o;
  logic             stall_i;
  logic [CHN-1:0]   mask_o, vld_o;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  v_alu_array #(.OP_WIDTH(OPW), .CH_NUM(CHN), .PIPE_DEPTH(PD), .V_LANE_NUM(1)) dut (
    .clk(clk), .rstn(rstn), .vld_i(vld_i), .op_i(op_i), .sew_i(sew_i), .a_i(a_i), .b_i(b_i),
    .red_i(red_i), .red_first_i(red_first_i), .red_last_i(red_last_i), .stall_i(stall_i),
    .res_o(res_o), .mask_o(mask_o), .vld_o(vld_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vld_i = '0; op_i = '0; sew_i = '0; a_i = '0; b_i = '0;
    red_i = '0; red_first_i = '0; red_last_i = '0;
  endtask

  task automatic set_ch(input int ch, input logic [3:0] op, input logic [1:0] sew,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic red, input logic first, input logic last);
    vld_i[ch] = 1'b1;
    op_i[ch*4 +: 4] = op;
    sew_i[ch*2 +: 2] = sew;
    a_i[ch*OPW +: OPW] = a;
    b_i[ch*OPW +: OPW] = b;
    red_i[ch] = red;
    red_first_i[ch] = first;
    red_last_i[ch] = last;
  endtask

  task automatic test_reset();
    idle(); stall_i = 1'b0; rstn = 1'b1;
    tick(); tick();
    rstn = 1'b0;
    checks++; if (vld_o !== 4'b0) begin errors++; $display("FAIL reset_vld got %h exp 0", vld_o); end
    checks++; if (res_o !== '0) begin errors++; $display("FAIL reset_res got %h exp 0", res_o); end
    checks++; if (mask_o !== 4'b0) begin errors++; $display("FAIL reset_mask got %h exp 0", mask_o); end
  endtask

  task automatic test_add_sew8();
    set_ch(0, 4'd0, 2'b00, 32'h0000_00F0, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    checks++; if (vld_o !== 4'b0) begin errors++; $display("FAIL add8_early got %h exp 0", vld_o); end
    tick();
    checks++; if (vld_o !== 4'b0001) begin errors++; $display("FAIL add8_vld got %h exp 1", vld_o); end
    checks++; if (res_o[31:0] !== 32'h1010_1010) begin errors++; $display("FAIL add8_res got %h exp 10101010", res_o[31:0]); end
    checks++; if (mask_o[0] !== 1'b0) begin errors++; $display("FAIL add8_mask got %b exp 0", mask_o[0]); end
    tick();
    checks++; if (vld_o !== 4'b0) begin errors++; $display("FAIL add8_pulse got %h exp 0", vld_o); end
  endtask

  task automatic test_per_channel_sew();
    set_ch(0, 4'd5,  2'b01, 32'h0000_0001, 32'h0000_0011, 1'b0, 1'b0, 1'b0);
    set_ch(1, 4'd1,  2'b01, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
    set_ch(2, 4'd15, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
    set_ch(3, 4'd10, 2'b00, 32'h0000_007F, 32'h0000_0085, 1'b0, 1'b0, 1'b0);
    tick(); idle(); tick();
    checks++; if (vld_o !== 4'b1111) begin errors++; $display("FAIL sew_vld got %h exp f", vld_o); end
    checks++; if (res_o !== 128'h85858585_00000001_FFFFFFFF_00020002) begin
      errors++; $display("FAIL sew_res got %h exp 85858585_00000001_ffffffff_00020002", res_o); end
    checks++; if (mask_o !== 4'b1110) begin errors++; $display("FAIL sew_mask got %b exp 1110", mask_o); end
  endtask

  task automatic test_shift_compare();
    set_ch(0, 4'd7,  2'b00, 32'h0000_0080, 32'h0000_0009, 1'b0, 1'b0, 1'b0);
    set_ch(1, 4'd9,  2'b01, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    set_ch(2, 4'd12, 2'b00, 32'h1234_5678, 32'h0000_0078, 1'b0, 1'b0, 1'b0);
    set_ch(3, 4'd6,  2'b10, 32'h8000_0000, 32'h0000_001F, 1'b0, 1'b0, 1'b0);
    tick(); idle(); tick();
    checks++; if (vld_o !== 4'b1111) begin errors++; $display("FAIL shift_vld got %h exp f", vld_o); end
    checks++; if (res_o !== 128'h00000001_01010101_80008000_C0C0C0C0) begin
      errors++; $display("FAIL shift_res got %h exp 00000001_01010101_80008000_c0c0c0c0", res_o); end
    checks++; if (mask_o !== 4'b1100) begin errors++; $display("FAIL shift_mask got %b exp 1100", mask_o); end
  endtask

  task automatic test_reduction();
    set_ch(1, 4'd1,  2'b10, 32'd3, 32'd10, 1'b1, 1'b1, 1'b1);
    set_ch(2, 4'd11, 2'b00, 32'h80, 32'h05, 1'b1, 1'b1, 1'b0);
    set_ch(3, 4'd0,  2'b10, 32'd1, 32'd10, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    checks++; if (vld_o !== 4'b0) begin errors++; $display("FAIL red_c0 got %h exp 0", vld_o); end
    set_ch(2, 4'd11, 2'b00, 32'h7F, 32'h0, 1'b1, 1'b0, 1'b0);
    set_ch(3, 4'd0,  2'b10, 32'd2, 32'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    checks++; if (vld_o !== 4'b0010) begin errors++; $display("FAIL red_one_vld got %h exp 2", vld_o); end
    checks++; if (res_o[63:32] !== 32'd7) begin errors++; $display("FAIL red_one_res got %h exp 7", res_o[63:32]); end
    set_ch(2, 4'd11, 2'b00, 32'hF0, 32'h0, 1'b1, 1'b0, 1'b0);
    set_ch(3, 4'd0,  2'b10, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    checks++; if (vld_o !== 4'b0) begin errors++; $display("FAIL red_c2 got %h exp 0", vld_o); end
    set_ch(2, 4'd11, 2'b00, 32'h10, 32'h0, 1'b1, 1'b0, 1'b1);
    set_ch(3, 4'd0,  2'b10, 32'd4, 32'd0, 1'b1, 1'b0, 1'b1);
    tick(); idle();
    checks++; if (vld_o !== 4'b0) begin errors++; $display("FAIL red_c3 got %h exp 0", vld_o); end
    tick();
    checks++; if (vld_o !== 4'b1100) begin errors++; $display("FAIL red_vld got %h exp c", vld_o); end
    checks++; if (res_o[127:96] !== 32'h0000_0014) begin errors++; $display("FAIL red_add got %h exp 14", res_o[127:96]); end
    checks++; if (res_o[95:64] !== 32'h7F7F_7F7F) begin errors++; $display("FAIL red_max got %h exp 7f7f7f7f", res_o[95:64]); end
    checks++; if (mask_o[3:2] !== 2'b01) begin errors++; $display("FAIL red_mask got %b exp 01", mask_o[3:2]); end
    tick();
    checks++; if (vld_o !== 4'b0) begin errors++; $display("FAIL red_pulse got %h exp 0", vld_o); end
  endtask

  task automatic test_stall();
    logic        exp_v [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] exp_d [11] = '{32'd0, 32'd100, 32'd100, 32'd100, 32'd100, 32'd101,
                                32'd102, 32'd103, 32'd104, 32'd105, 32'd0};
    logic [31:0] aval;
    for (int c = 0; c < 11; c++) begin
      idle();
      stall_i = (c >= 2 && c <= 4);
      if (c <= 8) begin
        aval = (c < 2) ? c : (c <= 4) ? 32'hDEAD : c - 3;
        set_ch(0, 4'd0, 2'b10, aval, 32'd100, 1'b0, 1'b0, 1'b0);
      end
      tick();
      checks++;
      if (vld_o[0] !== exp_v[c]) begin errors++; $display("FAIL stall_vld c=%0d got %b exp %b", c, vld_o[0], exp_v[c]); end
      if (exp_v[c]) begin
        checks++;
        if (res_o[31:0] !== exp_d[c]) begin errors++; $display("FAIL stall_res c=%0d got %h exp %h", c, res_o[31:0], exp_d[c]); end
      end
    end
    stall_i = 1'b0;
    idle();
  endtask

  task automatic test_reset_mid();
    set_ch(3, 4'd0, 2'b10, 32'd5, 32'd5, 1'b1, 1'b1, 1'b0);
    set_ch(0, 4'd0, 2'b10, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    tick(); idle();
    set_ch(1, 4'd0, 2'b10, 32'd2, 32'd2, 1'b0, 1'b0, 1'b0);
    set_ch(3, 4'd0, 2'b10, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0);
    tick(); idle();
    rstn = 1'b1; stall_i = 1'b1;
    tick();
    rstn = 1'b0; stall_i = 1'b0;
    checks++; if (vld_o !== 4'b0) begin errors++; $display("FAIL rmid_vld got %h exp 0", vld_o); end
    checks++; if (res_o !== '0) begin errors++; $display("FAIL rmid_res got %h exp 0", res_o); end
    checks++; if (mask_o !== 4'b0) begin errors++; $display("FAIL rmid_mask got %h exp 0", mask_o); end
    set_ch(3, 4'd0, 2'b10, 32'd3, 32'd4, 1'b1, 1'b1, 1'b0);
    tick(); idle();
    set_ch(3, 4'd0, 2'b10, 32'd1, 32'd0, 1'b1, 1'b0, 1'b1);
    tick(); idle();
    checks++; if (vld_o !== 4'b0) begin errors++; $display("FAIL rmid_drop got %h exp 0", vld_o); end
    tick();
    checks++; if (vld_o !== 4'b1000) begin errors++; $display("FAIL rmid_new_vld got %h exp 8", vld_o); end
    checks++; if (res_o[127:96] !== 32'd8) begin errors++; $display("FAIL rmid_new_res got %h exp 8", res_o[127:96]); end
  endtask

  initial begin
    test_reset();
    test_add_sew8();
    test_per_channel_sew();
    test_shift_compare();
    test_reduction();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
